// File: rtl/srt_stream_tx_pkg.sv
// Shared types and constants for the SRT frame transmitter.
// State encoding, header geometry and coefficient indexing.
package srt_stream_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PTS  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int HDR_BEATS = 3;
    localparam int NUM_COEF  = 12;

    // Header beat k, lane j carries coefficient 4k+j.
    function automatic logic [3:0] coef_idx(
        input logic [1:0] beat,
        input logic [1:0] lane
    );
        return {beat, lane};
    endfunction

endpackage

// File: rtl/srt_stream_tx_if.sv
// AXI-Stream bundle between the transmitter and the process block.
// Master drives data/valid/last, slave drives ready.
interface srt_stream_tx_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4
);

    logic [LANES*DATA_WIDTH-1:0] tdata;
    logic                        tvalid;
    logic                        tready;
    logic                        tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/srt_tx_fifo.sv
// Point buffer: synchronous FIFO with wrap-bit pointers.
// Caller guarantees no push when full and no pop when empty.
module srt_tx_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + (AW+1)'(1);
            if (pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_q[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_q[AW-1:0]];
    assign empty = (wr_q == rd_q);
    // Same slot, opposite lap: the writer is a full ring ahead.
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/srt_stream_tx.sv
// Frame builder: 3 matrix header beats then N buffered points.
// Header comes from a shadow bank latched at frame launch.
module srt_stream_tx
    import srt_stream_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        coef_wr,
    input  logic [3:0]                  coef_addr,
    input  logic [DATA_WIDTH-1:0]       coef_data,
    input  logic [LANES*DATA_WIDTH-1:0] pt_tdata,
    input  logic                        pt_tvalid,
    output logic                        pt_tready,
    input  logic                        start,
    input  logic [CNT_WIDTH-1:0]        num_points,
    srt_stream_tx_if.master             axis,
    output logic                        busy,
    output logic                        done,
    output logic                        start_err
);

    localparam int W = LANES * DATA_WIDTH;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] coef_q   [NUM_COEF];
    logic [DATA_WIDTH-1:0] shadow_q [NUM_COEF];
    logic [1:0]            hdr_cnt_q;
    logic [CNT_WIDTH-1:0]  pt_cnt_q;
    logic [W-1:0]          data_q;
    logic                  valid_q;
    logic                  last_q;
    logic                  err_q;
    logic                  rdy_q;

    logic [W-1:0] hdr0;
    logic [W-1:0] hdr_nxt;
    logic [W-1:0] fifo_dout;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    logic         hs;
    logic         start_ok;
    logic         hdr_end;
    logic         pt_slot;
    logic         ld_hdr0;
    logic         ld_hdr;
    logic         ld_pt;
    logic         drop;

    assign hs       = valid_q & axis.tready;
    assign start_ok = start && (state_q == S_IDLE) &&
                      (num_points != '0);
    assign hdr_end  = (state_q == S_HDR) && hs &&
                      (hdr_cnt_q == 2'(HDR_BEATS-1));
    // rdy_q keeps pt_tready low while reset is applied.
    assign pt_tready = rdy_q & ~fifo_full;
    assign push      = pt_tvalid & pt_tready;

    srt_tx_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (push),
        .din     (pt_tdata),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_COEF; i++)
                coef_q[i] <= '0;
        end else if (coef_wr && coef_addr < 4'(NUM_COEF)) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_COEF; i++)
                shadow_q[i] <= '0;
        end else if (start_ok) begin
            shadow_q <= coef_q;
        end
    end

    // Beat 0 leaves with the launch, so it reads the live bank.
    always_comb begin
        hdr0    = '0;
        hdr_nxt = '0;
        for (int j = 0; j < LANES; j++) begin
            hdr0[j*DATA_WIDTH +: DATA_WIDTH] =
                coef_q[coef_idx(2'd0, 2'(j))];
            hdr_nxt[j*DATA_WIDTH +: DATA_WIDTH] =
                shadow_q[coef_idx(hdr_cnt_q + 2'd1, 2'(j))];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start_ok)         state_d = S_HDR;
            S_HDR:  if (hdr_end)          state_d = S_PTS;
            S_PTS:  if (hs && last_q)     state_d = S_DONE;
            S_DONE:                       state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        ld_hdr0 = start_ok;
        ld_hdr  = (state_q == S_HDR) && hs && !hdr_end;
        pt_slot = hdr_end ||
                  ((state_q == S_PTS) && (pt_cnt_q != '0) &&
                   (!valid_q || hs));
        ld_pt   = pt_slot && !fifo_empty;
        drop    = hs && !ld_hdr && !ld_pt;
        pop     = ld_pt;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            unique case (1'b1)
                ld_hdr0: begin
                    data_q  <= hdr0;
                    valid_q <= 1'b1;
                    last_q  <= 1'b0;
                end
                ld_hdr: begin
                    data_q  <= hdr_nxt;
                    valid_q <= 1'b1;
                    last_q  <= 1'b0;
                end
                ld_pt: begin
                    data_q  <= fifo_dout;
                    valid_q <= 1'b1;
                    last_q  <= (pt_cnt_q == CNT_WIDTH'(1));
                end
                drop: begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // pt_cnt_q counts points not yet loaded into the output register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hdr_cnt_q <= '0;
            pt_cnt_q  <= '0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            err_q <= start && !start_ok;
            if (ld_hdr0)     hdr_cnt_q <= '0;
            else if (ld_hdr) hdr_cnt_q <= hdr_cnt_q + 2'd1;
            if (start_ok)    pt_cnt_q  <= num_points;
            else if (ld_pt)  pt_cnt_q  <= pt_cnt_q - CNT_WIDTH'(1);
        end
    end

    assign axis.tdata  = data_q;
    assign axis.tvalid = valid_q;
    assign axis.tlast  = last_q;
    assign start_err   = err_q;

endmodule

// File: tb/tb_srt_stream_tx.sv
// Directed bench for srt_stream_tx: frame content, stalls,
// bubbles, start rejection, full FIFO and mid-frame reset.
module tb_srt_stream_tx;

    typedef struct {
        logic [63:0] d;
        logic        l;
        int          c;
    } beat_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        coef_wr;
    logic [3:0]  coef_addr;
    logic [15:0] coef_data;
    logic [63:0] pt_tdata;
    logic        pt_tvalid;
    logic        pt_tready;
    logic        start;
    logic [15:0] num_points;
    logic        busy;
    logic        done;
    logic        start_err;

    srt_stream_tx_if #(.DATA_WIDTH(16), .LANES(4)) axis ();

    srt_stream_tx #(
        .DATA_WIDTH (16),
        .LANES      (4),
        .FIFO_DEPTH (16),
        .CNT_WIDTH  (16)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .coef_wr    (coef_wr),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .pt_tdata   (pt_tdata),
        .pt_tvalid  (pt_tvalid),
        .pt_tready  (pt_tready),
        .start      (start),
        .num_points (num_points),
        .axis       (axis),
        .busy       (busy),
        .done       (done),
        .start_err  (start_err)
    );

    always #5 aclk = ~aclk;

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          done_cnt = 0;
    int          gaps   = 0;
    logic        stall  = 1'b0;
    logic [63:0] pd;
    logic        pl;
    logic [15:0] cm [12];
    logic [63:0] pm [$];
    logic [63:0] exp_d [$];
    beat_t       beats [$];

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [63:0] pt_val(input int n);
        return {16'hCAFE, 16'(n), 16'(n + 100), 16'(n + 200)};
    endfunction

    function automatic logic [63:0] hdr(input int k);
        return {cm[4*k+3], cm[4*k+2], cm[4*k+1], cm[4*k]};
    endfunction

    task automatic wcoef(input int a, input logic [15:0] v);
        coef_wr   = 1'b1;
        coef_addr = 4'(a);
        coef_data = v;
        tick();
        coef_wr = 1'b0;
        if (a < 12) cm[a] = v;
    endtask

    task automatic push(input logic [63:0] v);
        pt_tvalid = 1'b1;
        pt_tdata  = v;
        tick();
        pt_tvalid = 1'b0;
        pm.push_back(v);
    endtask

    task automatic expect_frame(input int n);
        exp_d.delete();
        for (int k = 0; k < 3; k++) exp_d.push_back(hdr(k));
        for (int i = 0; i < n; i++) exp_d.push_back(pm.pop_front());
    endtask

    task automatic launch(input int n);
        beats.delete();
        gaps       = 0;
        num_points = 16'(n);
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            tick();
            if (done) ok = 1'b1;
        end
        chk(tag, 128'(ok), 128'(1));
        tick();
    endtask

    task automatic cmp_beats(input string tag);
        chk({tag, "_cnt"}, 128'(beats.size()), 128'(exp_d.size()));
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < beats.size()) begin
                chk($sformatf("%s_d%0d", tag, i),
                    128'(beats[i].d), 128'(exp_d[i]));
                chk($sformatf("%s_l%0d", tag, i),
                    128'(beats[i].l), 128'(i == exp_d.size() - 1));
            end
        end
    endtask

    // Observe mid-cycle: record handshakes, check held beats.
    always @(negedge aclk) begin
        if (!aresetn) begin
            stall = 1'b0;
        end else begin
            if (stall)
                chk("stable", {axis.tvalid, axis.tlast, axis.tdata},
                    {1'b1, pl, pd});
            if (axis.tvalid && axis.tready)
                beats.push_back('{axis.tdata, axis.tlast, cyc});
            if (done) done_cnt++;
            if (busy && !axis.tvalid && !done && beats.size() >= 3)
                gaps++;
            stall = axis.tvalid && !axis.tready;
            pd    = axis.tdata;
            pl    = axis.tlast;
        end
        cyc++;
    end

    initial begin
        int dc;
        aresetn     = 1'b0;
        coef_wr     = 1'b0;
        coef_addr   = '0;
        coef_data   = '0;
        pt_tdata    = '0;
        pt_tvalid   = 1'b0;
        start       = 1'b0;
        num_points  = '0;
        axis.tready = 1'b0;
        for (int i = 0; i < 12; i++) cm[i] = '0;
        repeat (3) tick();
        chk("rst_tvalid", 128'(axis.tvalid), 128'(0));
        chk("rst_tdata", 128'(axis.tdata), 128'(0));
        chk("rst_flags", 128'({axis.tlast, busy, done, start_err}),
            128'(0));
        chk("rst_pt_tready", 128'(pt_tready), 128'(0));
        aresetn = 1'b1;
        tick();
        chk("rdy_after_rst", 128'(pt_tready), 128'(1));
        axis.tready = 1'b1;

        // Basic frame, back-to-back
        for (int i = 0; i < 12; i++) wcoef(i, 16'(i + 1));
        push(pt_val(0));
        push(pt_val(1));
        expect_frame(2);
        launch(2);
        chk("t1_lat_valid", 128'(axis.tvalid), 128'(1));
        chk("t1_hdr0", 128'(axis.tdata),
            128'(64'h0004_0003_0002_0001));
        chk("t1_busy", 128'(busy), 128'(1));
        repeat (3) tick();
        chk("t1_pt0", 128'(axis.tdata), 128'(pt_val(0)));
        tick();
        chk("t1_last", 128'({axis.tlast, axis.tdata}),
            128'({1'b1, pt_val(1)}));
        tick();
        chk("t1_done", 128'({done, axis.tvalid}), 128'(2'b10));
        tick();
        chk("t1_idle", 128'({done, busy}), 128'(0));
        cmp_beats("t1");
        if (beats.size() == 5) begin
            chk("t1_hdr1", 128'(beats[1].d),
                128'(64'h0008_0007_0006_0005));
            chk("t1_hdr2", 128'(beats[2].d),
                128'(64'h000C_000B_000A_0009));
            chk("t1_cycles", 128'(beats[4].c - beats[0].c), 128'(4));
        end
        chk("t1_gaps", 128'(gaps), 128'(0));

        // Same frame with backpressure
        push(pt_val(0));
        push(pt_val(1));
        expect_frame(2);
        launch(2);
        for (int i = 0; i < 200 && !done; i++) begin
            axis.tready = (i % 2 == 0) && ($urandom_range(0, 3) != 0);
            tick();
        end
        chk("t2_done", 128'(done), 128'(1));
        axis.tready = 1'b1;
        tick();
        cmp_beats("t2");

        // Points trickle in after launch
        launch(3);
        for (int i = 0; i < 100 && !done; i++) begin
            pt_tvalid = (i == 3 || i == 7 || i == 11);
            pt_tdata  = pt_val(20 + i);
            if (pt_tvalid) pm.push_back(pt_tdata);
            tick();
            pt_tvalid = 1'b0;
        end
        chk("t3_done", 128'(done), 128'(1));
        tick();
        expect_frame(3);
        cmp_beats("t3");
        chk("t3_gaps_seen", 128'(gaps > 0), 128'(1));

        // Rejected starts and coefficient writes mid-frame
        num_points = 16'd0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_zero_err", 128'({start_err, axis.tvalid, busy}),
            128'(3'b100));
        tick();
        chk("t4_zero_quiet", 128'({start_err, axis.tvalid, busy}),
            128'(0));
        push(pt_val(40));
        expect_frame(1);
        launch(1);
        num_points = 16'd5;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_busy_err", 128'(start_err), 128'(1));
        wcoef(0, 16'h00AA);
        wait_done("t4_done", 50);
        cmp_beats("t4a");
        chk("t4_idle", 128'(busy), 128'(0));
        push(pt_val(41));
        expect_frame(1);
        launch(1);
        chk("t4_new_coef", 128'(axis.tdata),
            128'(64'h0004_0003_0002_00AA));
        wait_done("t4b_done", 50);
        cmp_beats("t4b");

        // Fill the FIFO, then drain it in one frame
        for (int i = 0; i < 16; i++) push(pt_val(60 + i));
        chk("t5_full", 128'(pt_tready), 128'(0));
        pt_tvalid = 1'b1;
        pt_tdata  = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        pt_tvalid = 1'b0;
        chk("t5_blocked", 128'(pt_tready), 128'(0));
        expect_frame(16);
        launch(16);
        wait_done("t5_done", 100);
        cmp_beats("t5");
        chk("t5_drained", 128'(pt_tready), 128'(1));

        // Reset in the point phase
        push(pt_val(80));
        push(pt_val(81));
        push(pt_val(82));
        launch(3);
        repeat (3) tick();
        chk("t6_in_pts", 128'(axis.tvalid), 128'(1));
        dc      = done_cnt;
        aresetn = 1'b0;
        tick();
        chk("t6_rst_out", 128'({axis.tvalid, axis.tlast, busy,
                                done, start_err, pt_tready}),
            128'(0));
        chk("t6_rst_data", 128'(axis.tdata), 128'(0));
        tick();
        aresetn = 1'b1;
        pm.delete();
        for (int i = 0; i < 12; i++) cm[i] = '0;
        repeat (5) tick();
        chk("t6_no_done", 128'(done_cnt), 128'(dc));
        chk("t6_idle", 128'({axis.tvalid, busy, pt_tready}),
            128'(3'b001));
        push(pt_val(90));
        push(pt_val(91));
        expect_frame(2);
        launch(2);
        wait_done("t6_done", 50);
        cmp_beats("t6");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
